// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush from freeze, mispredict, regfile and
// load-use hazards, with saturating stall/flush counters and a sticky stall watchdog.
module pipeline_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int STALL_MAX  = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [5:0]       hazard_op_i,
    input  logic             ld_use_i,
    input  logic             mispred_i,
    input  logic             dmem_busy_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             stall_timeout_o
);

    localparam int LW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
    localparam int RW = $clog2(STALL_MAX + 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LW-1:0]    ld_rem_q, ld_rem_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]    run_q, run_d;
    logic             timeout_q, timeout_d;
    logic             flush_inc;

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            ld_rem_q    <= {LW{1'b0}};
            pend_q      <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
            run_q       <= {RW{1'b0}};
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rem_q    <= ld_rem_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

    // Priority decode: reset, freeze, flush, regfile stall, load-use stall, run
    always_comb begin
        state_d       = state_q;
        ld_rem_d      = ld_rem_q;
        pend_d        = pend_q;
        flush_inc     = 1'b0;
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (!rst_ni) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_en_o    = 1'b0;
            ex_mem_en_o   = 1'b0;
            mem_wb_en_o   = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (dmem_busy_i) begin
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            mem_wb_en_o = 1'b0;
            pend_d      = pend_q | mispred_i;
        end else if (mispred_i || pend_q) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            pend_d        = 1'b0;
            ld_rem_d      = {LW{1'b0}};
            state_d       = RUN;
            flush_inc     = 1'b1;
        end else if (hazard_op_i == 6'b000111) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if ((state_q == LD_STALL) || ld_use_i) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            if (state_q == RUN) begin
                ld_rem_d = LW'(LOAD_STALL - 1);
                state_d  = (LOAD_STALL > 1) ? LD_STALL : RUN;
            end else begin
                // ld_rem is always >= 1 while parked in LD_STALL
                ld_rem_d = ld_rem_q - {{(LW-1){1'b0}}, 1'b1};
                state_d  = (ld_rem_q == {{(LW-1){1'b0}}, 1'b1}) ? RUN : LD_STALL;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Saturating perf counters and stall watchdog
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = run_q;
        if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        if (pc_en_o) begin
            run_d = {RW{1'b0}};
        end else if (run_q != RW'(STALL_MAX)) begin
            run_d = run_q + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            run_d = run_q;
        end
        timeout_d = timeout_q | (run_d == RW'(STALL_MAX));
    end

    assign stall_cnt_o     = stall_cnt_q;
    assign flush_cnt_o     = flush_cnt_q;
    assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one instance with LOAD_STALL=2/CNT_W=4 and one with defaults.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [5:0] hazard_op_i = 6'b000000;
    logic       ld_use_i = 1'b0;
    logic       mispred_i = 1'b0;
    logic       dmem_busy_i = 1'b0;

    logic       pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a, if_id_fl_a, id_ex_fl_a;
    logic [3:0] stall_cnt_a, flush_cnt_a;
    logic       timeout_a;
    logic       pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b, if_id_fl_b, id_ex_fl_b;
    logic [15:0] stall_cnt_b, flush_cnt_b;
    logic       timeout_b;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [6:0] O_RUN    = 7'b11111_00;
    localparam logic [6:0] O_STALL  = 7'b00111_01;
    localparam logic [6:0] O_FLUSH  = 7'b11111_11;
    localparam logic [6:0] O_FREEZE = 7'b00000_00;
    localparam logic [6:0] O_RST    = 7'b00000_11;

    pipeline_ctrl #(.LOAD_STALL(2), .STALL_MAX(8), .CNT_W(4)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hazard_op_i(hazard_op_i), .ld_use_i(ld_use_i),
        .mispred_i(mispred_i), .dmem_busy_i(dmem_busy_i),
        .pc_en_o(pc_en_a), .if_id_en_o(if_id_en_a), .id_ex_en_o(id_ex_en_a),
        .ex_mem_en_o(ex_mem_en_a), .mem_wb_en_o(mem_wb_en_a),
        .if_id_flush_o(if_id_fl_a), .id_ex_flush_o(id_ex_fl_a),
        .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a), .stall_timeout_o(timeout_a)
    );

    pipeline_ctrl u_dflt (
        .clk_i(clk_i), .rst_ni(rst_ni), .hazard_op_i(hazard_op_i), .ld_use_i(ld_use_i),
        .mispred_i(mispred_i), .dmem_busy_i(dmem_busy_i),
        .pc_en_o(pc_en_b), .if_id_en_o(if_id_en_b), .id_ex_en_o(id_ex_en_b),
        .ex_mem_en_o(ex_mem_en_b), .mem_wb_en_o(mem_wb_en_b),
        .if_id_flush_o(if_id_fl_b), .id_ex_flush_o(id_ex_fl_b),
        .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b), .stall_timeout_o(timeout_b)
    );

    always #5 clk_i = ~clk_i;

    wire [6:0] outs_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a, if_id_fl_a, id_ex_fl_a};
    wire [6:0] outs_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b, if_id_fl_b, id_ex_fl_b};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs; outputs are then sampled at the following negedge
    task automatic drive(input logic rst, input logic [5:0] hop, input logic ld,
                         input logic mp, input logic busy);
        rst_ni      = rst;
        hazard_op_i = hop;
        ld_use_i    = ld;
        mispred_i   = mp;
        dmem_busy_i = busy;
        @(negedge clk_i);
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
        advance();
    endtask

    initial begin
        // T1: reset
        drive(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t1_rst_outs_c0", {25'd0, outs_a}, {25'd0, O_RST});
        advance();
        drive(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t1_rst_outs_c1", {25'd0, outs_a}, {25'd0, O_RST});
        check_eq("t1_rst_outs_dflt", {25'd0, outs_b}, {25'd0, O_RST});
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t1_run_after_rst", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t1_stall_cnt", {28'd0, stall_cnt_a}, 32'd0);
        check_eq("t1_flush_cnt", {28'd0, flush_cnt_a}, 32'd0);
        check_eq("t1_timeout", {31'd0, timeout_a}, 32'd0);
        advance();

        // T2: load-use, two bubbles with LOAD_STALL=2, one with default
        drive(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
        check_eq("t2_ld_c0", {25'd0, outs_a}, {25'd0, O_STALL});
        check_eq("t2_ld_c0_dflt", {25'd0, outs_b}, {25'd0, O_STALL});
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t2_ld_c1", {25'd0, outs_a}, {25'd0, O_STALL});
        check_eq("t2_ld_c1_dflt", {25'd0, outs_b}, {25'd0, O_RUN});
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t2_ld_c2", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t2_stall_cnt", {28'd0, stall_cnt_a}, 32'd2);
        check_eq("t2_stall_cnt_dflt", {16'd0, stall_cnt_b}, 32'd1);
        advance();

        // T3: regfile-wait stall vs. unrelated hazard_op
        drive(1'b1, 6'b000111, 1'b0, 1'b0, 1'b0);
        check_eq("t3_rf_stall", {25'd0, outs_a}, {25'd0, O_STALL});
        advance();
        drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b0);
        check_eq("t3_other_op", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t3_stall_cnt", {28'd0, stall_cnt_a}, 32'd3);
        advance();

        // T4: mispredict during LD_STALL
        do_reset();
        drive(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
        check_eq("t4_ld_entry", {25'd0, outs_a}, {25'd0, O_STALL});
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b1, 1'b0);
        check_eq("t4_flush", {25'd0, outs_a}, {25'd0, O_FLUSH});
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t4_run_after", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t4_flush_cnt", {28'd0, flush_cnt_a}, 32'd1);
        check_eq("t4_stall_cnt", {28'd0, stall_cnt_a}, 32'd1);
        advance();

        // T5: freeze defers a mispredict
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'b000000, 1'b0, (i == 1) ? 1'b1 : 1'b0, 1'b1);
            check_eq($sformatf("t5_freeze_c%0d", i), {25'd0, outs_a}, {25'd0, O_FREEZE});
            advance();
        end
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t5_deferred_flush", {25'd0, outs_a}, {25'd0, O_FLUSH});
        check_eq("t5_stall_cnt", {28'd0, stall_cnt_a}, 32'd3);
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t5_run_after", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t5_flush_cnt", {28'd0, flush_cnt_a}, 32'd1);
        check_eq("t5_no_timeout", {31'd0, timeout_a}, 32'd0);
        advance();

        // T6: long freeze, counter saturation and watchdog
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b1);
            check_eq($sformatf("t6_cnt_c%0d", i), {28'd0, stall_cnt_a}, (i > 15) ? 32'd15 : i);
            check_eq($sformatf("t6_to_c%0d", i), {31'd0, timeout_a}, (i >= 8) ? 32'd1 : 32'd0);
            advance();
        end
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t6_run_after", {25'd0, outs_a}, {25'd0, O_RUN});
        check_eq("t6_cnt_sat", {28'd0, stall_cnt_a}, 32'd15);
        check_eq("t6_cnt_dflt", {16'd0, stall_cnt_b}, 32'd20);
        advance();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t6_timeout_sticky", {31'd0, timeout_a}, 32'd1);
        check_eq("t6_timeout_dflt", {31'd0, timeout_b}, 32'd1);
        advance();
        do_reset();
        drive(1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
        check_eq("t6_timeout_cleared", {31'd0, timeout_a}, 32'd0);
        advance();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
